// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: state codes,
// opcodes, ALU operation codes and datapath select values.
package riscv_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Only beq (000) and bne (001) are implemented; others trap.
    function automatic logic is_supported_branch(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001);
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format select; purely combinational, independent of state.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V main controller: Moore state decode plus the FETCH
// enables and the branch-resolved PCWrite, all enables gated by reset.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = is_supported_branch(funct3) ? S_BRANCH : S_TRAP;
                    OP_JAL:            w_next_state = S_JAL;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_TRAP;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_MEMDATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                ALUOp    = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_TRAP:  w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    // Gating with rst_n drops enables immediately, without waiting for a clock edge.
    assign PCWrite  = rst_n & (w_pc_update | (w_branch & (zero ^ funct3[0])));
    assign IRWrite  = rst_n & w_ir_write;
    assign MemWrite = rst_n & w_mem_write;
    assign RegWrite = rst_n & w_reg_write;
    assign illegal  = rst_n & w_illegal;
    assign state    = r_state;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm with hand-written
// sequences for trap hold and asynchronous reset mid-store.
module tb_multicycle_control_fsm;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] SYS = 7'b1110011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, mw, rw, adr;
        logic [1:0] rs, sa, sb, aop, imm;
        logic       ill;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vq[$];
    out_t act;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
    );

    assign act = '{state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};

    function automatic out_t o(input int st, input bit pcw, irw, mw, rw, adr,
                               input int rs, sa, sb, aop, imm, input bit ill);
        out_t r;
        r.st = 4'(st); r.pcw = pcw; r.irw = irw; r.mw = mw; r.rw = rw; r.adr = adr;
        r.rs = 2'(rs); r.sa = 2'(sa); r.sb = 2'(sb); r.aop = 2'(aop); r.imm = 2'(imm);
        r.ill = ill;
        return r;
    endfunction

    task automatic check(input string name, input logic [19:0] a, input logic [19:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", name, a, e);
    endtask

    task automatic add(input logic [6:0] vop, input int f3, input bit z, input bit rdy, input out_t e);
        vec_t v;
        v.op = vop; v.f3 = 3'(f3); v.z = z; v.rdy = rdy; v.exp = e;
        vq.push_back(v);
    endtask

    // Called just after a posedge; each row checks the current cycle, then steps one clock.
    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            op = vq[i].op; funct3 = vq[i].f3; zero = vq[i].z; mem_ready = vq[i].rdy;
            #1;
            check($sformatf("%s[%0d]", tag, i), act, vq[i].exp);
            @(posedge clk); #1;
        end
        vq.delete();
    endtask

    // Fetch + decode rows for an instruction that proceeds with mem_ready=1.
    task automatic add_fd(input logic [6:0] vop, input int f3, input bit z, input int imm);
        add(vop, f3, z, 1, o(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, imm, 0));
        add(vop, f3, z, 1, o(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, imm, 0));
    endtask

    task automatic reset_pulse(input string tag);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, {state, PCWrite, IRWrite, MemWrite, RegWrite, illegal},
              {4'd0, 5'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; op = R; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        check("reset_state", act, o(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type add: 0,1,6,8
        add_fd(R, 0, 0, 0);
        add(R, 0, 0, 1, o(6, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
        add(R, 0, 0, 1, o(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // I-type with one fetch stall
        add(I, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        add_fd(I, 0, 0, 0);
        add(I, 0, 0, 1, o(7, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0));
        add(I, 0, 0, 1, o(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // lw with three MEMREAD stalls
        add_fd(LD, 2, 0, 0);
        add(LD, 2, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(LD, 2, 0, 0, o(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(LD, 2, 0, 1, o(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(LD, 2, 0, 1, o(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // sw with one MEMWRITE stall
        add_fd(ST, 2, 0, 1);
        add(ST, 2, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        add(ST, 2, 0, 0, o(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(ST, 2, 0, 1, o(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        // beq z=1 taken, bne z=1 not taken, bne z=0 taken
        add_fd(BR, 0, 1, 2);
        add(BR, 0, 1, 1, o(9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));
        add_fd(BR, 1, 1, 2);
        add(BR, 1, 1, 1, o(9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));
        add_fd(BR, 1, 0, 2);
        add(BR, 1, 0, 1, o(9, 1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0));
        // jal: 0,1,10,8
        add_fd(JL, 0, 0, 3);
        add(JL, 0, 0, 1, o(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
        add(JL, 0, 0, 1, o(8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        // unsupported opcode reaches TRAP
        add_fd(SYS, 0, 0, 0);
        add(SYS, 0, 0, 1, o(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run_table("main");

        // TRAP holds regardless of mem_ready/zero until reset
        for (int k = 0; k < 12; k++) begin
            mem_ready = k[0]; zero = k[1];
            #1;
            check($sformatf("trap_hold[%0d]", k), act, o(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            @(posedge clk); #1;
        end
        reset_pulse("trap_reset");

        // branch with funct3=010 traps
        add_fd(BR, 2, 0, 2);
        add(BR, 2, 0, 1, o(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
        run_table("bad_branch");
        reset_pulse("bad_branch_reset");

        // sw interrupted by reset while MemWrite is active
        add_fd(ST, 2, 0, 1);
        add(ST, 2, 0, 1, o(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        add(ST, 2, 0, 0, o(5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
        run_table("sw_pre");
        #1;
        check("sw_mw_before_reset", {state, MemWrite}, {4'd5, 1'b1});
        rst_n = 1'b0;
        #1;
        check("sw_mw_async_drop", {state, MemWrite}, {4'd0, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1; op = R; mem_ready = 1'b1;
        #1;
        check("post_reset_fetch", act, o(0, 1, 1, 0, 0, 0, 2, 0, 2, 0, 0, 0));
        @(posedge clk); #1;
        check("post_reset_decode", {28'd0, state}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 clk  in  1  rising-edge clock, the only clock.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 op  in  7  instruction opcode, instr[6:0].
REQ-004 funct3  in  3  instr[14:12]; also routed directly to the ALU funct3 input.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completes the current access this cycle.
REQ-007 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  write enables and address select (AdrSrc 0=PC, 1=ALU result register).
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc  out  2 each  datapath selects; ALUOp 00=add, 01=sub, 10=decode funct3.
REQ-009 illegal  out  1  unsupported opcode or branch funct3 trapped.
REQ-010 state  out  4  current state code, for debug.

Function
REQ-011 The FSM SHALL use the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10 and TRAP=15.
REQ-012 The output decode SHALL be Moore from state, except the FETCH enables and PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])).
REQ-013 Every enable not listed for a state SHALL be 0, and every select not listed SHALL be 00.
REQ-014 FETCH: ALUSrcB=10 (constant 4), ResultSrc=10, and IRWrite = PCUpdate = mem_ready; the FSM SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-015 DECODE: ALUSrcA=01 (oldPC), ALUSrcB=01 (imm); next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011 with funct3 000/001->BRANCH, 1101111->JAL, anything else->TRAP.
REQ-016 MEMADR: ALUSrcA=10 (rs1), ALUSrcB=01; next state MEMREAD for loads, MEMWRITE for stores.
REQ-017 MEMREAD: AdrSrc=1; the FSM SHALL hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
REQ-019 MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle in the state; the FSM SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL go to ALUWB.
REQ-021 ALUWB: RegWrite=1; next state FETCH.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1 (beq taken on zero, bne on !zero); next state FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1; next state ALUWB.
REQ-024 TRAP: illegal=1 and all enables 0; the FSM SHALL stay in TRAP until reset.
REQ-025 ImmSrc SHALL be decoded combinationally from op: I/load 00, store 01, branch 10, jal 11, others 00.
REQ-026 With mem_ready held at 1, instruction latency SHALL be: lw 5 cycles, sw/R/I/jal 4 cycles, branch 3 cycles.

Reset
REQ-027 While rst_n=0: state=FETCH, illegal=0, and PCWrite, IRWrite, MemWrite and RegWrite forced to 0, asynchronously, including mid-instruction (an in-flight MemWrite drops immediately).
REQ-028 After rst_n rises, the first rising clk edge SHALL be evaluated as FETCH.

Structure
REQ-029 The state encodings, ALUOp codes, opcode constants and select encodings SHALL live in the shared package riscv_ctrl_pkg.
REQ-030 The block SHALL have one sub-module, imm_src_decoder, holding the op->ImmSrc table; next-state and output decode stay in the top module.

Verification
REQ-031 R-type add (op 0110011), mem_ready=1 -> state sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUOp=10 in EXECR.
REQ-032 lw with mem_ready low for 3 cycles in MEMREAD -> 3 stall cycles in state 3, then 4,0; RegWrite pulses once.
REQ-033 beq with zero=1, then bne with zero=1 -> PCWrite=1 in BRANCH for beq, PCWrite=0 for bne.
REQ-034 op=1110011 -> TRAP; illegal=1 held; all enables 0 for 10 or more cycles until rst_n pulses low.
REQ-035 sw with rst_n asserted mid-MEMWRITE -> MemWrite falls without a clk edge; state=0 after release.
